// File: rtl/approx_mult_scheduler.sv
// Purpose: round-robin arbiter sharing one approximate multiplier core across n_requesters clients, with a Done watchdog.
// Latency: request to done_out is (core latency)+2 cycles; a timed-out operation responds in cycle timeout+2 with err_out set.
// Backpressure: clients hold req until gnt; the core is never restarted until Done or watchdog abort, and req is not sampled outside IDLE.
module approx_mult_scheduler #(
  parameter int n_requesters = 4,
  parameter int n_input      = 16,
  parameter int timeout      = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [n_requesters-1:0]         req,
  input  logic [n_requesters*n_input-1:0] a_in,
  input  logic [n_requesters*n_input-1:0] b_in,
  output logic [n_requesters-1:0]         gnt,
  output logic [n_requesters-1:0]         done_out,
  output logic                            err_out,
  output logic [2*n_input-1:0]            result,
  output logic                            busy,
  output logic                            mul_start,
  output logic [n_input-1:0]              mul_a,
  output logic [n_input-1:0]              mul_b,
  input  logic                            mul_done,
  input  logic [2*n_input-1:0]            mul_product
);

  localparam int PW = $clog2(n_requesters);
  localparam int CW = $clog2(timeout + 1);
  // Counter value in the last WAIT cycle before the watchdog fires
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(timeout);
  localparam logic [PW-1:0] SEL_LAST = PW'(n_requesters - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [PW-1:0]             sel_q, sel_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [n_input-1:0]        opa_q, opa_d;
  logic [n_input-1:0]        opb_q, opb_d;
  logic [n_requesters-1:0]   gnt_q, gnt_d;
  logic [n_requesters-1:0]   done_q, done_d;
  logic                      err_q, err_d;
  logic [2*n_input-1:0]      result_q, result_d;
  logic                      busy_q, busy_d;
  logic                      start_q, start_d;

  logic                      win_found;
  logic [PW-1:0]             win_idx;

  // Round-robin pick: first requesting client at or after ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < n_requesters; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % n_requesters]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + i) % n_requesters);
      end
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so every port is a flop
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // mul_done is ignored here, so a Done from an abandoned operation has no effect
        if (win_found) begin
          state_d        = ISSUE;
          sel_d          = win_idx;
          opa_d          = a_in[int'(win_idx)*n_input +: n_input];
          opb_d          = b_in[int'(win_idx)*n_input +: n_input];
          gnt_d[win_idx] = 1'b1;
          start_d        = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Done takes priority over a watchdog expiry in the same cycle
        if (mul_done) begin
          state_d       = RESP;
          result_d      = mul_product;
          done_d[sel_q] = 1'b1;
          err_d         = 1'b0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d       = RESP;
          result_d      = '0;
          done_d[sel_q] = 1'b1;
          err_d         = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously so outputs drop the moment rst rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign gnt       = gnt_q;
  assign done_out  = done_q;
  assign err_out   = err_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign mul_start = start_q;
  assign mul_a     = opa_q;
  assign mul_b     = opb_q;

endmodule

// File: tb/tb_approx_mult_scheduler.sv
// Bench for approx_mult_scheduler: behavioural core responder, round-robin reference model, scoreboard with a separate monitor.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_approx_mult_scheduler;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  a_in = '0;
  logic [N*W-1:0]  b_in = '0;
  logic [N-1:0]    gnt, done_out;
  logic            err_out, busy, mul_start, mul_done;
  logic [2*W-1:0]  result, mul_product;
  logic [W-1:0]    mul_a, mul_b;

  logic            core_done = 1'b0;
  logic            stray_done = 1'b0;
  logic [2*W-1:0]  core_prod = '0;
  int              core_lat = 1;
  bit              core_hang = 1'b0;
  int              core_cnt = 0;
  logic [W-1:0]    pa = '0, pb = '0;

  int              cyc = 0;
  int              checks = 0;
  int              failures = 0;
  int              ptr_m = 0;
  logic [N-1:0]    last_gnt = '0;

  typedef struct {
    logic [N-1:0]   d;
    logic [2*W-1:0] r;
    logic           e;
    int             c;
  } exp_t;
  exp_t sb[$];

  assign mul_done    = core_done | stray_done;
  assign mul_product = stray_done ? 32'hDEAD_BEEF : core_prod;

  approx_mult_scheduler #(.n_requesters(N), .n_input(W), .timeout(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done_out(done_out), .err_out(err_out), .result(result),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: Done arrives core_lat cycles after the Start cycle, product is junk otherwise
  always @(negedge clk) begin
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      core_done = (core_cnt == 0);
    end else begin
      core_done = 1'b0;
    end
    core_prod = core_done ? 32'(pa) * 32'(pb) : 32'($urandom);
    if (mul_start && !core_hang) begin
      core_cnt = core_lat;
      pa = mul_a;
      pb = mul_b;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int i = 0; i < N; i++)
      if (p[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_out != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done_out), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_out", 64'(done_out), 64'(e.d));
          chk("result", 64'(result), 64'(e.r));
          chk("err_out", 64'(err_out), 64'(e.e));
          chk("resp_cycle", 64'(cyc), 64'(e.c));
        end
      end
    end
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = 16'($urandom);
      b_in[i*W +: W] = 16'($urandom);
    end
  endtask

  task automatic op(input logic [N-1:0] pat, input int lat, input bit hang,
                    input bit keep, input bit stray);
    int win, g, span;
    bit got;
    exp_t e;
    logic [W-1:0] ea, eb;
    logic [N-1:0] oh;
    core_lat = lat;
    core_hang = hang;
    req = pat;
    stray_done = stray;
    win = pick(pat, ptr_m);
    span = hang ? TMO : lat;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("gnt_arrives", 64'd0, 64'd1);
      stray_done = 1'b0;
      req = '0;
      return;
    end
    g = cyc;
    last_gnt = gnt;
    oh = '0;
    oh[win] = 1'b1;
    ea = a_in[win*W +: W];
    eb = b_in[win*W +: W];
    chk("gnt", 64'(gnt), 64'(oh));
    chk("mul_start", 64'(mul_start), 64'd1);
    chk("busy_issue", 64'(busy), 64'd1);
    chk("mul_a", 64'(mul_a), 64'(ea));
    chk("mul_b", 64'(mul_b), 64'(eb));
    e.d = oh;
    e.r = hang ? 32'd0 : 32'(ea) * 32'(eb);
    e.e = hang;
    e.c = g + span + 1;
    sb.push_back(e);
    ptr_m = (win + 1) % N;
    if (!keep) req = '0;
    @(negedge clk);
    stray_done = 1'b0;
    chk("gnt_one_cycle", {60'd0, gnt}, 64'd0);
    chk("start_one_cycle", 64'(mul_start), 64'd0);
    got = 1'b0;
    for (int k = 0; k < TMO + 20; k++) begin
      @(negedge clk);
      if (!busy) begin got = 1'b1; break; end
    end
    chk("idle_cycle", got ? 64'(cyc) : 64'hFFFF, 64'(g + span + 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    stray_done = 1'b0;
    core_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    sb.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_done_out"}, 64'(done_out), 64'd0);
    chk({tag, "_err_out"}, 64'(err_out), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
    chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
    chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
  endtask

  initial begin
    logic [N-1:0] prev;
    bit got;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests from reset: 1 then 3, then ptr is back at 0
    randomize_operands();
    op(4'b1010, 3, 1'b0, 1'b1, 1'b0);
    op(4'b1010, 5, 1'b0, 1'b0, 1'b0);
    op(4'b1111, 2, 1'b0, 1'b0, 1'b0);

    // Single request with fixed operands, Done in cycle 5
    a_in[0 +: W] = 16'd300;
    b_in[0 +: W] = 16'd7;
    op(4'b0001, 4, 1'b0, 1'b0, 1'b0);

    // Fairness: all clients held high for eight operations
    do_reset();
    randomize_operands();
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      op(4'b1111, 1 + (i % 3), 1'b0, (i < 7), 1'b0);
      chk("no_repeat_grant", 64'(last_gnt != prev), 64'd1);
      prev = last_gnt;
    end

    // Watchdog abort, then a normal operation
    randomize_operands();
    op(4'b0100, 1, 1'b1, 1'b0, 1'b0);
    op(4'b1001, 6, 1'b0, 1'b0, 1'b0);

    // Stray Done in IDLE with nothing requested
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_idle_busy", 64'(busy), 64'd0);

    // Stray Done in IDLE and ISSUE around a real operation
    op(4'b0010, 7, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 20; i++) begin
      randomize_operands();
      op(4'($urandom_range(1, 15)), $urandom_range(1, 12), 1'b0, 1'b0,
         ($urandom_range(0, 9) == 0));
    end

    // Reset in cycle 10 of an operation whose Done would come in cycle 21
    randomize_operands();
    a_in[1*W +: W] = 16'h1234;
    b_in[1*W +: W] = 16'h0056;
    core_lat = 20;
    core_hang = 1'b0;
    req = 4'b0010;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    chk("midwait_gnt", 64'(got), 64'd1);
    req = '0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    repeat (15) @(negedge clk);
    chk("late_done_busy", 64'(busy), 64'd0);
    op(4'b0100, 3, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_mult_scheduler.md
# approx_mult_scheduler

Round-robin scheduler that shares one approximate multiplier core among `n_requesters` clients. It sits between the client ports and the core's Start/Done handshake, and owns the following:
- arbitration between clients;
- operand capture;
- the Start pulse to the core;
- result return to the winning client;
- a watchdog that aborts a core operation that never signals Done.

## Interface
Parameters:
- `n_requesters`, 4: number of clients, ≥2.
- `n_input`, 16: operand width. Must match the core's `n_input`.
- `timeout`, 64: maximum number of WAIT cycles before abort, ≥1.

Ports:
- `clk`  in  1: the single clock. All logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  n_requesters: per-client request. Held high until granted.
- `a_in`  in  n_requesters*n_input: client i's operand A is in slice [i*n_input +: n_input].
- `b_in`  in  n_requesters*n_input: client i's operand B, same slicing as `a_in`.
- `gnt`  out  n_requesters: one-hot, one-cycle grant.
- `done_out`  out  n_requesters: one-hot, one-cycle completion pulse.
- `err_out`  out  1: high together with `done_out` when the operation timed out.
- `result`  out  2*n_input: product. Valid while `done_out` is nonzero.
- `busy`  out  1: high in every state except IDLE.
- `mul_start`  out  1: one-cycle Start pulse to the core.
- `mul_a`, `mul_b`  out  n_input each: operands to the core.
- `mul_done`  in  1: Done from the core.
- `mul_product`  in  2*n_input: product from the core.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - When `req` is nonzero, select the first set bit at or after `ptr`, searching upward and wrapping modulo `n_requesters`.
  - Latch the winner's index into `sel` and its `a_in`/`b_in` slices into the operand registers.
  - Go to ISSUE.
  - When `req` is zero, stay in IDLE.
- **ISSUE** (one cycle)
  - `gnt[sel]` = 1 and `mul_start` = 1.
  - Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - `mul_a`/`mul_b` hold the latched operands, stable from ISSUE through RESP.
  - The counter increments every cycle.
  - When `mul_done` = 1: capture `mul_product` into `result`, clear the error flag, go to RESP.
  - Otherwise, when the counter reaches `timeout`: set `result` = 0, set the error flag, go to RESP.
  - If `mul_done` and the timeout coincide, `mul_done` wins and no error is raised.
- **RESP** (one cycle)
  - `done_out[sel]` = 1.
  - `err_out` = error flag.
  - Set `ptr` = (`sel`+1) mod `n_requesters`.
  - Go to IDLE.
- **Client behaviour**
  - A client may drop `req` after its `gnt`.
  - A `req` still high when the scheduler returns to IDLE is treated as a new request.
  - A `req` that deasserts before being granted is simply not served; nothing is recorded.
- **Stray Done:** `mul_done` during IDLE, ISSUE or RESP is ignored and has no state effect.
- **Arithmetic:** no arithmetic in this block. `result` is passed through unmodified at 2*n_input bits. The counter is clog2(`timeout`+1) bits and saturates at `timeout`.
- **Reset** (any state, including mid-WAIT):
  - State returns to IDLE; `ptr`, `sel`, the counter and the operand registers go to 0.
  - All outputs go to 0: `gnt`, `done_out`, `err_out`, `result`, `busy`, `mul_start`, `mul_a`, `mul_b`.
  - An in-flight core operation is abandoned. A later `mul_done` from it arrives in IDLE and is ignored.

## Timing
- Take cycle 0 as the IDLE cycle in which `req` is sampled nonzero.
- Cycle 1: ISSUE. `gnt` and `mul_start` are high for this one cycle only.
- WAIT starts in cycle 2. If `mul_done` is sampled high in cycle d (d≥2), RESP is cycle d+1 and IDLE is cycle d+2.
- Total latency from request to `done_out` is (core latency)+2 cycles, where core latency = d−1, counted from the Start cycle to the Done cycle.
- Timeout: with no `mul_done`, RESP occurs in cycle `timeout`+2, with `err_out` = 1.
- A back-to-back request is granted at earliest in cycle d+3.
- All outputs are registered. No combinational path exists from `req` or `mul_done` to any output.

## Test plan
- **Single request:** `req`=4'b0001, A=300, B=7; the core returns Done in cycle 5 with product 2100. Required:
  - `gnt`=0001 and `mul_start`=1 in cycle 1;
  - `done_out`=0001 and `result`=2100 in cycle 6, with `err_out`=0;
  - `busy` returns to 0 in cycle 7.
- **Simultaneous requests:** `req`=4'b1010 from reset. Client 1 is served first, then client 3. `ptr`=0 after the second RESP.
- **Round-robin fairness:** all four `req` held high for 8 operations. Grant order is 0,1,2,3,0,1,2,3, and no client is granted twice in a row.
- **Timeout:** with `timeout`=64, the core never asserts Done. Required in cycle 66: `done_out`[sel]=1, `err_out`=1, `result`=0. The next request proceeds normally.
- **Reset mid-WAIT:** assert `rst` in cycle 10 of an operation. Required:
  - all outputs read 0 immediately, since reset is asynchronous;
  - the late `mul_done` after release has no effect;
  - a new `req`=0100 is granted to client 2.
- **Stray Done:** pulse `mul_done` in IDLE and in ISSUE. No `done_out` is produced, and the operation completes only on a `mul_done` seen during WAIT.
